// File: rtl/debounce_botones_pkg.sv
// Shared definitions for the button debouncer: channel state encoding and
// the default stability window for the 50 MHz board clock.
package debounce_botones_pkg;

    // Channel state encoding. The two WAIT states hold the candidate new level
    // until it has been stable long enough.
    typedef enum logic [1:0] {
        S_LOW       = 2'd0,
        S_WAIT_HIGH = 2'd1,
        S_HIGH      = 2'd2,
        S_WAIT_LOW  = 2'd3
    } estado_t;

    // 20 ms at 50 MHz.
    localparam int DEBOUNCE_CYCLES_DEF = 1000000;

endpackage

// File: rtl/debounce_botones_if.sv
// Button bundle: raw inputs toward the debouncer, clean level and edge
// pulses back out. master = board/stimulus side, slave = debouncer side.
interface debounce_botones_if #(
    parameter int N_BTN = 3
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_rise;
    logic [N_BTN-1:0] btn_fall;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_rise,
        input  btn_fall
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_rise,
        output btn_fall
    );
endinterface

// File: rtl/debounce_botones_canal.sv
// Single debounce channel: two-flop synchroniser, four-state acceptance FSM
// with a stability counter, and registered level/rise/fall outputs.
//
// state        | meaning
// -------------+------------------------------------------------------------
// S_LOW        | accepted level is 0, input agrees
// S_WAIT_HIGH  | accepted level is 0, input has been 1 for cnt samples
// S_HIGH       | accepted level is 1, input agrees
// S_WAIT_LOW   | accepted level is 1, input has been 0 for cnt samples
module debounce_canal
    import debounce_botones_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall
);

    localparam int                 CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             btn_sync;
    estado_t          estado;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser; only btn_sync is used past this point.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1  <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            sync_q1  <= btn_raw;
            btn_sync <= sync_q1;
        end
    end

    // Acceptance FSM plus outputs registered from the current state; a rise
    // is the first cycle the registered level catches up with S_HIGH.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado    <= S_LOW;
            cnt       <= '0;
            btn_level <= 1'b0;
            btn_rise  <= 1'b0;
            btn_fall  <= 1'b0;
        end else begin
            btn_level <= (estado == S_HIGH) || (estado == S_WAIT_LOW);
            btn_rise  <= (estado == S_HIGH) && !btn_level;
            btn_fall  <= (estado == S_LOW)  &&  btn_level;

            case (estado)
                S_LOW: begin
                    if (btn_sync) begin
                        estado <= S_WAIT_HIGH;
                        cnt    <= CNT_W'(1);
                    end else begin
                        cnt    <= '0;
                    end
                end
                S_WAIT_HIGH: begin
                    if (!btn_sync) begin
                        estado <= S_LOW;
                        cnt    <= '0;
                    end else if (cnt == CNT_LAST) begin
                        estado <= S_HIGH;
                        cnt    <= '0;
                    end else begin
                        cnt    <= cnt + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (!btn_sync) begin
                        estado <= S_WAIT_LOW;
                        cnt    <= CNT_W'(1);
                    end else begin
                        cnt    <= '0;
                    end
                end
                S_WAIT_LOW: begin
                    if (btn_sync) begin
                        estado <= S_HIGH;
                        cnt    <= '0;
                    end else if (cnt == CNT_LAST) begin
                        estado <= S_LOW;
                        cnt    <= '0;
                    end else begin
                        cnt    <= cnt + 1'b1;
                    end
                end
                default: begin
                    estado <= S_LOW;
                    cnt    <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/debounce_botones.sv
// Debouncer for the board push-buttons: N_BTN independent channels, each
// delivering a clean level and one-cycle rise/fall pulses.
module debounce_botones
    import debounce_botones_pkg::*;
#(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    debounce_botones_if.slave  bus
);

    logic [N_BTN-1:0] level_v;
    logic [N_BTN-1:0] rise_v;
    logic [N_BTN-1:0] fall_v;

    for (genvar i = 0; i < N_BTN; i++) begin : g_canal
        debounce_canal #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_canal (
            .clk       (clk),
            .rst       (rst),
            .btn_raw   (bus.btn_raw[i]),
            .btn_level (level_v[i]),
            .btn_rise  (rise_v[i]),
            .btn_fall  (fall_v[i])
        );
    end

    // Channel outputs are already registered; this just routes them out.
    always_comb begin
        bus.btn_level = level_v;
        bus.btn_rise  = rise_v;
        bus.btn_fall  = fall_v;
    end

endmodule

// File: tb/tb_debounce_botones.sv
// Bench for debounce_botones: directed scenarios plus random bouncing,
// checked against a run-length reference model through a scoreboard queue.
module tb_debounce_botones;
    localparam int N = 3;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    debounce_botones_if #(.N_BTN(N)) bus ();

    debounce_botones #(.N_BTN(N), .DEBOUNCE_CYCLES(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [N-1:0] level;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: raw seen through a 2-sample delay line; a channel's
    // accepted level flips once D consecutive delayed samples disagree with
    // it. Outputs show the accepted level one edge later, and a pulse in the
    // cycle after each flip.
    logic [N-1:0] m_d0 = '0, m_d1 = '0, m_acc = '0, m_rose = '0, m_fell = '0;
    int           m_run [N];

    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            e.level = '0; e.rise = '0; e.fall = '0;
            m_d0 = '0; m_d1 = '0; m_acc = '0; m_rose = '0; m_fell = '0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
        end else begin
            e.level = m_acc;
            e.rise  = m_rose;
            e.fall  = m_fell;
            m_rose  = '0;
            m_fell  = '0;
            for (int i = 0; i < N; i++) begin
                if (m_d1[i] != m_acc[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == D) begin
                        m_acc[i]  = ~m_acc[i];
                        m_rose[i] = m_acc[i];
                        m_fell[i] = ~m_acc[i];
                        m_run[i]  = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_d1 = m_d0;
            m_d0 = bus.btn_raw;
        end
        sb_q.push_back(e);
    end

    // Monitor: outputs are presented every cycle; compare each against the
    // oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if ({bus.btn_level, bus.btn_rise, bus.btn_fall} !== {e.level, e.rise, e.fall}) begin
                errors++;
                $display("FAIL sb_out t=%0t level=%b rise=%b fall=%b expected level=%b rise=%b fall=%b",
                         $time, bus.btn_level, bus.btn_rise, bus.btn_fall, e.level, e.rise, e.fall);
            end
            checks++;
            if ((bus.btn_rise & bus.btn_fall) != '0) begin
                errors++;
                $display("FAIL rise_fall_excl t=%0t rise=%b fall=%b expected no overlap",
                         $time, bus.btn_rise, bus.btn_fall);
            end
        end
    end

    task automatic drive(input logic [N-1:0] r, input logic rr);
        @(negedge clk);
        bus.btn_raw = r;
        rst         = rr;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_bits(input string name, input logic [2:0] act, input logic [2:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    initial begin
        int got;
        bus.btn_raw = '1;
        rst         = 1'b1;

        // Reset held two cycles with all buttons pressed.
        @(negedge clk);
        check_bits("reset_out1", {bus.btn_level[0], bus.btn_rise[0], bus.btn_fall[0]}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        check_bits("reset_lvl2", bus.btn_level, 3'b000);
        @(negedge clk);
        check_bits("post_reset_lvl", bus.btn_level, 3'b000);
        check_bits("post_reset_rise", bus.btn_rise, 3'b000);
        idle(8);
        check_bits("accept_high_lvl", bus.btn_level, 3'b111);

        // Release everything, then a clean rise on channel 0 with exact latency.
        drive(3'b000, 1'b0);
        idle(10);
        check_bits("released_lvl", bus.btn_level, 3'b000);
        drive(3'b001, 1'b0);
        for (int i = 0; i <= 6; i++) begin
            @(posedge clk); #1;
            if (i == 5) check_bits("lat_before", {2'b00, bus.btn_level[0]}, 3'b000);
            if (i == 6) check_bits("lat_edge", {1'b0, bus.btn_level[0], bus.btn_rise[0]}, 3'b011);
        end
        @(posedge clk); #1;
        check_bits("rise_one_cycle", {2'b00, bus.btn_rise[0]}, 3'b000);

        // Bounce on channel 1 before settling high.
        drive(3'b011, 1'b0); idle(1);
        drive(3'b001, 1'b0); idle(1);
        drive(3'b011, 1'b0); idle(1);
        drive(3'b001, 1'b0); idle(1);
        drive(3'b011, 1'b0);
        idle(10);
        check_bits("bounce_settled", bus.btn_level, 3'b011);

        // Three-cycle low glitch on channel 0 while accepted high.
        drive(3'b010, 1'b0); idle(2);
        drive(3'b011, 1'b0);
        idle(8);
        check_bits("glitch_lvl", bus.btn_level, 3'b011);

        // Simultaneous rises on 0 and 1, channel 2 two cycles later.
        drive(3'b000, 1'b0);
        idle(10);
        drive(3'b011, 1'b0); idle(1);
        drive(3'b111, 1'b0);
        idle(10);

        // Reset during the third cycle of S_WAIT_HIGH on channel 0.
        drive(3'b000, 1'b1);
        drive(3'b000, 1'b0);
        idle(10);
        drive(3'b001, 1'b0);
        idle(4);
        drive(3'b001, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        got = -1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.btn_rise[0]) begin
                got = i;
                break;
            end
        end
        checks++;
        if (got != 6) begin
            errors++;
            $display("FAIL rst_wait_rise actual_edges=%0d required=6", got);
        end

        // Random bouncing with occasional resets.
        begin
            logic [N-1:0] r;
            r = bus.btn_raw;
            for (int c = 0; c < 3000; c++) begin
                for (int i = 0; i < N; i++)
                    if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
                drive(r, ($urandom_range(0, 299) == 0));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 8));
            end
        end
        drive('0, 1'b0);
        idle(12);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/debounce_botones.md
Name: debounce_botones

Overview:
Conditions the raw push-button inputs (up, down, enable and similar) from the board before they reach the up/down counter and other control logic.
- Per channel: synchronises the asynchronous input, rejects bounce shorter than a programmable window, and outputs a clean level plus one-cycle rise/fall pulses.
- Sits directly upstream of the 4-bit counter: btn_level drives its up/down/enable level inputs.

Parameters:
N_BTN, 3, number of independent button channels (minimum 1).
DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised samples required to accept a change (20 ms at 50 MHz); minimum 2.
CNT_W, derived localparam = $clog2(DEBOUNCE_CYCLES+1), width of the per-channel stability counter; not overridable.

Ports:
clk  input  1  system clock; all logic on posedge clk.
rst  input  1  reset, synchronous, active-high.
btn_raw  input  N_BTN  asynchronous, bouncy button inputs, active-high.
btn_level  output  N_BTN  debounced level per channel.
btn_rise  output  N_BTN  one-cycle pulse when btn_level goes 0->1.
btn_fall  output  N_BTN  one-cycle pulse when btn_level goes 1->0.

Behaviour:
- Reset (rst=1 at a clock edge): synchroniser flops, btn_level, btn_rise and btn_fall all 0; every channel goes to S_LOW; counters 0. Reset overrides any in-progress wait; a pending change is discarded.
- Synchroniser: two-flop chain per channel. btn_sync reflects btn_raw after 2 edges. Only btn_sync is used downstream of the chain.
- Per-channel FSM states: S_LOW, S_WAIT_HIGH, S_HIGH, S_WAIT_LOW.
  - S_LOW: btn_sync=1 -> S_WAIT_HIGH, cnt=1; otherwise stay, cnt=0.
  - S_WAIT_HIGH: btn_sync=0 -> S_LOW, cnt=0 (bounce rejected, no output change). btn_sync=1 and cnt=DEBOUNCE_CYCLES-1 -> S_HIGH, cnt=0. Otherwise cnt+1.
  - S_HIGH and S_WAIT_LOW: mirror image with btn_sync inverted.
- Outputs are registered.
  - btn_level=1 in S_HIGH and S_WAIT_LOW; 0 in S_LOW and S_WAIT_HIGH.
  - btn_rise=1 for exactly the one cycle following the S_WAIT_HIGH->S_HIGH transition; btn_fall likewise for S_WAIT_LOW->S_LOW.
- Latency: a clean raw edge is visible on btn_level 2 + DEBOUNCE_CYCLES clock edges later.
- Glitch rejection: any raw pulse whose synchronised width is shorter than DEBOUNCE_CYCLES cycles produces no level change and no pulses.
- Counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Channels are fully independent. Simultaneous changes on several channels are each accepted on their own schedule. btn_rise and btn_fall are never both 1 on the same channel.
- No combinational path from btn_raw to any output.

Decomposition:
- Shared package: 2-bit state encoding constants (S_LOW=0, S_WAIT_HIGH=1, S_HIGH=2, S_WAIT_LOW=3) and the default DEBOUNCE_CYCLES for the 50 MHz board clock.
- Sub-module debounce_canal: single channel containing synchroniser, FSM, counter and pulse generation. The top instantiates N_BTN copies in a generate loop.

Test Plan:
- DEBOUNCE_CYCLES=4. Hold rst 2 cycles with btn_raw=3'b111 -> all outputs 0 during and on the first cycle after reset. Channels then accept the highs per the latency rule.
- DEBOUNCE_CYCLES=4. btn_raw[0] 0->1 clean at edge k -> btn_level[0]=1 and btn_rise[0]=1 after edge k+6. btn_rise[0] returns to 0 after edge k+7.
- DEBOUNCE_CYCLES=4. btn_raw[1] toggles 1,0,1,0,1 every 2 cycles, then stays 1 -> no pulse during bouncing. A single btn_rise[1] fires 6 cycles after the final stable 1.
- DEBOUNCE_CYCLES=4. btn_level[0]=1, then a 3-cycle low glitch on btn_raw[0] -> btn_level[0] stays 1 and no btn_fall[0].
- DEBOUNCE_CYCLES=4. btn_raw[0] and btn_raw[1] rise together, btn_raw[2] rises 2 cycles later -> rise pulses on channels 0 and 1 in the same cycle, channel 2 exactly 2 cycles later.
- DEBOUNCE_CYCLES=4. rst asserted at the 3rd cycle of S_WAIT_HIGH -> no btn_rise. After rst release with input still high, a full 2+4 cycle wait precedes btn_rise.
